// File: rtl/sap_exec_ctrl_pkg.sv
// rtl/sap_exec_ctrl_pkg.sv - opcode, stage and flag constants for the SAP execution core
package sap_exec_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam logic [2:0] ST_FETCH_ADDR  = 3'd0;
    localparam logic [2:0] ST_FETCH_INSTR = 3'd1;
    localparam logic [2:0] ST_EXEC0       = 3'd2;
    localparam logic [2:0] ST_EXEC1       = 3'd3;
    localparam logic [2:0] ST_EXEC2       = 3'd4;

    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/sap_tick_gen.sv
// rtl/sap_tick_gen.sv - divider producing a one-cycle tick every DIV fclk cycles
module sap_tick_gen #(
    parameter int DIV = 500000
) (
    input  logic fclk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge fclk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sap_exec_ctrl.sv
// rtl/sap_exec_ctrl.sv - SAP microcode controller, A/B registers and ALU gated by the tick
module sap_exec_ctrl
    import sap_exec_ctrl_pkg::*;
#(
    parameter int DIV = 500000
) (
    input  logic       fclk,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic [2:0] stage,
    input  logic [1:0] flags,
    input  logic [7:0] bus,
    output logic       tick,
    output logic       ctrl_ai,
    output logic       ctrl_ao,
    output logic       ctrl_bi,
    output logic       ctrl_ce,
    output logic       ctrl_co,
    output logic       ctrl_eo,
    output logic       ctrl_fi,
    output logic       ctrl_ht,
    output logic       ctrl_ii,
    output logic       ctrl_io,
    output logic       ctrl_jp,
    output logic       ctrl_mi,
    output logic       ctrl_oi,
    output logic       ctrl_ri,
    output logic       ctrl_ro,
    output logic       ctrl_su,
    output logic [7:0] a_reg,
    output logic [8:0] alu,
    output logic       flag_c,
    output logic       flag_z
);

    logic [7:0] b_reg;
    logic       unused_ir_low;

    assign unused_ir_low = ^ir[3:0];

    sap_tick_gen #(.DIV(DIV)) u_tick_gen (
        .fclk  (fclk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge fclk) begin
        if (reset) begin
            a_reg <= 8'h00;
            b_reg <= 8'h00;
        end else if (tick) begin
            if (ctrl_ai) a_reg <= bus;
            if (ctrl_bi) b_reg <= bus;
        end
    end

    // Subtract is A + ~B + 1, so carry out means no borrow.
    assign alu    = {1'b0, a_reg} + {1'b0, (ctrl_su ? ~b_reg : b_reg)} + {8'h00, ctrl_su};
    assign flag_c = alu[8];
    assign flag_z = (alu[7:0] == 8'h00);

    always_comb begin
        ctrl_ai = 1'b0;
        ctrl_ao = 1'b0;
        ctrl_bi = 1'b0;
        ctrl_ce = 1'b0;
        ctrl_co = 1'b0;
        ctrl_eo = 1'b0;
        ctrl_fi = 1'b0;
        ctrl_ht = 1'b0;
        ctrl_ii = 1'b0;
        ctrl_io = 1'b0;
        ctrl_jp = 1'b0;
        ctrl_mi = 1'b0;
        ctrl_oi = 1'b0;
        ctrl_ri = 1'b0;
        ctrl_ro = 1'b0;
        ctrl_su = 1'b0;
        case (stage)
            ST_FETCH_ADDR: begin
                ctrl_co = 1'b1;
                ctrl_mi = 1'b1;
            end
            ST_FETCH_INSTR: begin
                ctrl_ro = 1'b1;
                ctrl_ii = 1'b1;
                ctrl_ce = 1'b1;
            end
            ST_EXEC0: begin
                case (ir[7:4])
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_io = 1'b1;
                        ctrl_mi = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl_io = 1'b1;
                        ctrl_ai = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_io = 1'b1;
                        ctrl_jp = 1'b1;
                    end
                    OP_JC: begin
                        ctrl_io = flags[FLAG_C];
                        ctrl_jp = flags[FLAG_C];
                    end
                    OP_JZ: begin
                        ctrl_io = flags[FLAG_Z];
                        ctrl_jp = flags[FLAG_Z];
                    end
                    OP_OUT: begin
                        ctrl_ao = 1'b1;
                        ctrl_oi = 1'b1;
                    end
                    OP_HLT: ctrl_ht = 1'b1;
                    default: ;
                endcase
            end
            ST_EXEC1: begin
                case (ir[7:4])
                    OP_LDA: begin
                        ctrl_ro = 1'b1;
                        ctrl_ai = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_ro = 1'b1;
                        ctrl_bi = 1'b1;
                    end
                    OP_STA: begin
                        ctrl_ao = 1'b1;
                        ctrl_ri = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                if (ir[7:4] == OP_ADD || ir[7:4] == OP_SUB) begin
                    ctrl_eo = 1'b1;
                    ctrl_ai = 1'b1;
                    ctrl_fi = 1'b1;
                    ctrl_su = (ir[7:4] == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sap_exec_ctrl.sv
// tb/tb_sap_exec_ctrl.sv - directed self-checking bench for sap_exec_ctrl
module tb_sap_exec_ctrl;

    localparam logic [15:0] AI = 16'h8000;
    localparam logic [15:0] AO = 16'h4000;
    localparam logic [15:0] BI = 16'h2000;
    localparam logic [15:0] CE = 16'h1000;
    localparam logic [15:0] CO = 16'h0800;
    localparam logic [15:0] EO = 16'h0400;
    localparam logic [15:0] FI = 16'h0200;
    localparam logic [15:0] HT = 16'h0100;
    localparam logic [15:0] II = 16'h0080;
    localparam logic [15:0] IO = 16'h0040;
    localparam logic [15:0] JP = 16'h0020;
    localparam logic [15:0] MI = 16'h0010;
    localparam logic [15:0] OI = 16'h0008;
    localparam logic [15:0] RI = 16'h0004;
    localparam logic [15:0] RO = 16'h0002;
    localparam logic [15:0] SU = 16'h0001;

    typedef struct packed {
        logic [7:0]  ir;
        logic [2:0]  stage;
        logic [1:0]  flags;
        logic [15:0] exp;
    } vec_t;

    logic       fclk;
    logic       reset;
    logic [7:0] ir;
    logic [2:0] stage;
    logic [1:0] flags;
    logic [7:0] bus;

    logic       tick1, tick4;
    logic [15:0] c1, c4;
    logic [7:0] a1, a4;
    logic [8:0] alu1, alu4;
    logic       fc1, fz1, fc4, fz4;

    int n_tests = 0;
    int n_fail  = 0;

    sap_exec_ctrl #(.DIV(1)) dut1 (
        .fclk(fclk), .reset(reset), .ir(ir), .stage(stage), .flags(flags), .bus(bus),
        .tick(tick1),
        .ctrl_ai(c1[15]), .ctrl_ao(c1[14]), .ctrl_bi(c1[13]), .ctrl_ce(c1[12]),
        .ctrl_co(c1[11]), .ctrl_eo(c1[10]), .ctrl_fi(c1[9]), .ctrl_ht(c1[8]),
        .ctrl_ii(c1[7]), .ctrl_io(c1[6]), .ctrl_jp(c1[5]), .ctrl_mi(c1[4]),
        .ctrl_oi(c1[3]), .ctrl_ri(c1[2]), .ctrl_ro(c1[1]), .ctrl_su(c1[0]),
        .a_reg(a1), .alu(alu1), .flag_c(fc1), .flag_z(fz1)
    );

    sap_exec_ctrl #(.DIV(4)) dut4 (
        .fclk(fclk), .reset(reset), .ir(ir), .stage(stage), .flags(flags), .bus(bus),
        .tick(tick4),
        .ctrl_ai(c4[15]), .ctrl_ao(c4[14]), .ctrl_bi(c4[13]), .ctrl_ce(c4[12]),
        .ctrl_co(c4[11]), .ctrl_eo(c4[10]), .ctrl_fi(c4[9]), .ctrl_ht(c4[8]),
        .ctrl_ii(c4[7]), .ctrl_io(c4[6]), .ctrl_jp(c4[5]), .ctrl_mi(c4[4]),
        .ctrl_oi(c4[3]), .ctrl_ri(c4[2]), .ctrl_ro(c4[1]), .ctrl_su(c4[0]),
        .a_reg(a4), .alu(alu4), .flag_c(fc4), .flag_z(fz4)
    );

    initial begin
        fclk = 1'b0;
        forever #5 fclk = ~fclk;
    end

    task automatic apply_reset();
        @(negedge fclk);
        reset = 1'b1;
        ir = 8'h00; stage = 3'd5; flags = 2'b00; bus = 8'h00;
        repeat (2) @(negedge fclk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_tests++;
        if (a4 !== 8'h00 || alu4 !== 9'h000 || fz4 !== 1'b1 || fc4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state4: a=%h alu=%h z=%b c=%b required a=00 alu=000 z=1 c=0", a4, alu4, fz4, fc4);
        end
        n_tests++;
        if (a1 !== 8'h00 || alu1 !== 9'h000 || fz1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state1: a=%h alu=%h z=%b required a=00 alu=000 z=1", a1, alu1, fz1);
        end
    endtask

    task automatic test_tick();
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge fclk);
            #1;
            n_tests++;
            if (tick4 !== ((k % 4) == 0)) begin
                n_fail++;
                $display("FAIL tick_div4 cycle %0d: got %b required %b", k, tick4, ((k % 4) == 0));
            end
        end
        n_tests++;
        if (tick1 !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_div1: got %b required 1", tick1);
        end
    endtask

    task automatic test_alu_add_sub();
        apply_reset();
        ir = 8'h50; stage = 3'd2; bus = 8'h05;
        @(negedge fclk);
        ir = 8'h20; stage = 3'd3; bus = 8'h03;
        @(negedge fclk);
        ir = 8'h00; stage = 3'd5;
        #1;
        n_tests++;
        if (a1 !== 8'h05 || alu1 !== 9'h008) begin
            n_fail++;
            $display("FAIL alu_add_5_3: a=%h alu=%h required a=05 alu=008", a1, alu1);
        end
        ir = 8'h30; stage = 3'd4; bus = 8'h05;
        #1;
        n_tests++;
        if (alu1 !== 9'h102 || fc1 !== 1'b1 || fz1 !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_sub_5_3: alu=%h c=%b z=%b required alu=102 c=1 z=0", alu1, fc1, fz1);
        end
    endtask

    task automatic test_alu_boundary();
        @(negedge fclk);
        ir = 8'h50; stage = 3'd2; bus = 8'hFF;
        @(negedge fclk);
        ir = 8'h20; stage = 3'd3; bus = 8'h01;
        @(negedge fclk);
        ir = 8'h00; stage = 3'd5;
        #1;
        n_tests++;
        if (alu1 !== 9'h100 || fc1 !== 1'b1 || fz1 !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_add_wrap: alu=%h c=%b z=%b required alu=100 c=1 z=1", alu1, fc1, fz1);
        end
        @(negedge fclk);
        ir = 8'h50; stage = 3'd2; bus = 8'h01;
        @(negedge fclk);
        ir = 8'h20; stage = 3'd3; bus = 8'h02;
        @(negedge fclk);
        ir = 8'h30; stage = 3'd4; bus = 8'h01;
        #1;
        n_tests++;
        if (alu1 !== 9'h0FF || fc1 !== 1'b0 || fz1 !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_sub_borrow: alu=%h c=%b z=%b required alu=0ff c=0 z=0", alu1, fc1, fz1);
        end
    endtask

    task automatic test_controller();
        vec_t tbl [22];
        tbl = '{
            '{8'h2F, 3'd0, 2'b00, CO | MI},
            '{8'h2F, 3'd1, 2'b00, RO | II | CE},
            '{8'h2F, 3'd2, 2'b00, IO | MI},
            '{8'h2F, 3'd3, 2'b00, RO | BI},
            '{8'h2F, 3'd4, 2'b00, EO | AI | FI},
            '{8'h2F, 3'd5, 2'b00, 16'h0000},
            '{8'h3F, 3'd4, 2'b00, EO | AI | SU | FI},
            '{8'h74, 3'd2, 2'b10, IO | JP},
            '{8'h74, 3'd2, 2'b00, 16'h0000},
            '{8'h80, 3'd2, 2'b01, IO | JP},
            '{8'h80, 3'd2, 2'b10, 16'h0000},
            '{8'hE0, 3'd2, 2'b00, AO | OI},
            '{8'hF0, 3'd2, 2'b00, HT},
            '{8'h5A, 3'd2, 2'b00, IO | AI},
            '{8'h93, 3'd2, 2'b11, 16'h0000},
            '{8'h1C, 3'd3, 2'b00, RO | AI},
            '{8'h40, 3'd3, 2'b00, AO | RI},
            '{8'h60, 3'd2, 2'b00, IO | JP},
            '{8'hF0, 3'd7, 2'b00, 16'h0000},
            '{8'hD0, 3'd2, 2'b11, 16'h0000},
            '{8'h00, 3'd0, 2'b11, CO | MI},
            '{8'hE0, 3'd3, 2'b00, 16'h0000}
        };
        for (int i = 0; i < 22; i++) begin
            @(negedge fclk);
            ir = tbl[i].ir; stage = tbl[i].stage; flags = tbl[i].flags;
            #1;
            n_tests++;
            if (c4 !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL ctrl ir=%h st=%0d fl=%b: got %h required %h",
                         tbl[i].ir, tbl[i].stage, tbl[i].flags, c4, tbl[i].exp);
            end
        end
        flags = 2'b00;
    endtask

    task automatic test_tick_gating();
        apply_reset();
        ir = 8'h50; stage = 3'd2; bus = 8'h77;
        repeat (3) @(negedge fclk);
        #1;
        n_tests++;
        if (a4 !== 8'h00 || tick4 !== 1'b1) begin
            n_fail++;
            $display("FAIL gate_no_tick: a=%h tick=%b required a=00 tick=1", a4, tick4);
        end
        @(negedge fclk);
        #1;
        n_tests++;
        if (a4 !== 8'h77) begin
            n_fail++;
            $display("FAIL gate_on_tick: a=%h required 77", a4);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        bus = 8'h11;
        @(negedge fclk);
        #1;
        n_tests++;
        if (a4 !== 8'h00 || tick4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: a=%h tick=%b required a=00 tick=0", a4, tick4);
        end
        n_tests++;
        if (c4 !== (IO | AI)) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h required %h", c4, IO | AI);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ir = 8'h00; stage = 3'd5; flags = 2'b00; bus = 8'h00;
        test_reset();
        test_tick();
        test_alu_add_sub();
        test_alu_boundary();
        test_controller();
        test_tick_gating();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_exec_ctrl.md
Name: sap_exec_ctrl

Overview:
- Execution/control core of the 8-bit SAP-style CPU.
- Combines three functions:
  - a clock-enable tick generator (clock divider);
  - the microcode controller, which decodes opcode, microstage and flags into 16 control lines;
  - the ALU with its A and B registers and 9-bit add/subtract result.
- Sits between the instruction register, stage counter, flags register and the shared 8-bit bus.
- All state is clocked by one fast clock and gated by the internal tick.

Parameters:
- DIV, 500000, fast-clock cycles per tick (>=1). DIV=1 means tick is high every cycle.

Ports:
- fclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ir  in  8  instruction register; opcode = ir[7:4].
- stage  in  3  microstep 0..7 from the stage counter.
- flags  in  2  registered flags; flags[1]=C, flags[0]=Z.
- bus  in  8  shared data bus value.
- tick  out  1  one-fclk-cycle enable for all CPU registers.
- ctrl_ai, ctrl_ao, ctrl_bi, ctrl_ce, ctrl_co, ctrl_eo, ctrl_fi, ctrl_ht, ctrl_ii, ctrl_io, ctrl_jp, ctrl_mi, ctrl_oi, ctrl_ri, ctrl_ro, ctrl_su  out  1 each  control lines.
- a_reg  out  8  accumulator A.
- alu  out  9  ALU result, with carry in bit 8.
- flag_c  out  1  alu[8].
- flag_z  out  1  high when alu[7:0]==0.

Behaviour:
- Tick counter:
  - cnt counts 0..DIV-1 on fclk and wraps to 0.
  - tick=1 exactly when cnt==DIV-1, giving a period of DIV cycles.
  - Reset sets cnt=0, so the first tick comes DIV cycles after reset deasserts.
- A/B registers (B is internal, 8 bits):
  - Updated only on fclk edges where tick=1.
  - ctrl_ai=1 loads A<=bus; ctrl_bi=1 loads B<=bus. Both may load in the same tick.
  - Reset clears A and B to 0, regardless of tick.
- ALU (combinational):
  - ctrl_su=0: alu = {0,A} + {0,B}.
  - ctrl_su=1: alu = {0,A} + {0,~B} + 1, so carry=1 means no borrow (A>=B).
  - Result wraps modulo 256 in alu[7:0].
  - flag_c and flag_z are derived from the current alu value; the external flags register latches them on ctrl_fi.
- Controller:
  - Purely combinational from ir[7:4], stage and flags. Independent of tick and reset.
  - Every line not listed for a step below is 0.
- Fetch, for every opcode:
  - stage0: co, mi.
  - stage1: ro, ii, ce.
- Execute, stage2 onward, by opcode:
  - NOP 0: nothing.
  - LDA 1: s2 io,mi; s3 ro,ai.
  - ADD 2: s2 io,mi; s3 ro,bi; s4 eo,ai,fi.
  - SUB 3: s2 io,mi; s3 ro,bi; s4 eo,ai,su,fi.
  - STA 4: s2 io,mi; s3 ao,ri.
  - LDI 5: s2 io,ai.
  - JMP 6: s2 io,jp.
  - JC 7: s2 io,jp only if flags[1]=1; otherwise nothing.
  - JZ 8: s2 io,jp only if flags[0]=1; otherwise nothing.
  - OUT 14 (E): s2 ao,oi.
  - HLT 15 (F): s2 ht.
  - Opcodes 9-13: behave as NOP.
- Stages 5-7 assert nothing for every opcode. Steps beyond an instruction's last listed stage assert nothing.
- Reset mid-operation: A, B and cnt clear on the next fclk edge. Control outputs keep following their inputs.

Decomposition:
- Shared package holds:
  - the opcode constants OP_NOP..OP_HLT;
  - the stage constants;
  - the flag bit indices FLAG_C=1 and FLAG_Z=0.
- Natural sub-module: sap_tick_gen, the parameterised divider producing tick.
- The controller decode and the ALU stay in the top module.

Test Plan:
- DIV=4, reset for 2 cycles then release: tick pulses on fclk cycles 4, 8, 12 after release; A=0, B=0, alu=0, flag_z=1.
- DIV=1: bus=0x05 with ai for one tick, then bus=0x03 with bi: A=5, B=3; su=0 gives alu=0x008; su=1 gives alu=0x102, flag_c=1.
- A=0xFF, B=0x01, su=0: alu=0x100, flag_c=1, flag_z=1. Then A=0x01, B=0x02, su=1: alu=0x0FF, flag_c=0, flag_z=0.
- Controller sweep:
  - ir=0x2F: stage0 gives co+mi only; stage1 ro+ii+ce; stage2 io+mi; stage3 ro+bi; stage4 eo+ai+fi (su=0); stage5 nothing.
  - ir=0x3F at stage4: adds su.
- Conditional jumps at stage2:
  - ir=0x74 with flags=2'b10: io+jp; with flags=2'b00: nothing.
  - ir=0x80 with flags=2'b01: io+jp; with flags=2'b10: nothing.
- Remaining opcodes at stage2:
  - ir=0xE0: ao+oi. ir=0xF0: ht. ir=0x5A: io+ai. ir=0x9x: nothing.
- ai held with bus=0x77 while tick=0: A unchanged. Assert reset between ticks: A clears immediately on the next edge.
